signal_edge_capture: RTL and testbench



---
 rtl/signal_edge_capture_pkg.sv | 18 +
 rtl/signal_edge_capture_filter.sv | 69 ++++++
 rtl/signal_edge_capture.sv | 85 ++++++++
 tb/tb_signal_edge_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/signal_edge_capture_pkg.sv
// Shared definitions for the signal_edge_capture block: edge-mode encodings
// and the helper that decides whether a filtered transition is counted.
package signal_edge_capture_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // True when a transition of the given direction counts toward the accumulator.
  function automatic logic edge_qualifies(input int mode, input logic rise, input logic fall);
    logic take_rise;
    logic take_fall;
    take_rise = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    take_fall = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    return (rise && take_rise) || (fall && take_fall);
  endfunction

endpackage

// File: rtl/signal_edge_capture_filter.sv
// sync_glitch_filter: debounces an already-synchronized level. The filtered
// level only follows the input after FILTER_LEN consecutive differing samples,
// and registered rise/fall pulses accompany each change of the filtered level.
// The *_nxt outputs expose the pulse one cycle early so a consumer can register
// its own reaction in the same cycle the pulse appears.
module sync_glitch_filter
  import signal_edge_capture_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic o_clk,
  input  logic rst,
  input  logic i_signal,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  // FILTER_LEN is at most 255, so an 8-bit run counter always suffices.
  localparam logic [7:0] LAST_CNT = 8'(FILTER_LEN - 1);

  logic       level_q, level_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       rise_q,  rise_d;
  logic       fall_q,  fall_d;

  // Next-state: count the differing run, commit the new level on its last sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (i_signal == level_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == LAST_CNT) begin
      level_d = i_signal;
      cnt_d   = 8'd0;
      rise_d  = i_signal;
      fall_d  = ~i_signal;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers; reset discards any partial run and never emits a pulse.
  always_ff @(posedge o_clk) begin
    if (rst) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= 8'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level    = level_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_rise_nxt = rise_d & ~rst;
  assign o_fall_nxt = fall_d & ~rst;

endmodule

// File: rtl/signal_edge_capture.sv
// signal_edge_capture: glitch-filters a synchronized level, emits rise/fall
// pulses and accumulates qualifying edges in a saturating counter that a
// consumer drains through a valid/ready handshake. An edge arriving in the
// same cycle as a read is carried into the fresh count rather than dropped.
module signal_edge_capture
  import signal_edge_capture_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                 o_clk,
  input  logic                 rst,
  input  logic                 i_signal,
  output logic                 o_level,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic                 o_evt_valid,
  input  logic                 i_evt_ready,
  output logic [CNT_WIDTH-1:0] o_evt_count,
  output logic                 o_overflow,
  input  logic                 i_clr_ovf
);

  localparam logic [CNT_WIDTH-1:0] ACC_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ACC_ONE = CNT_WIDTH'(1);

  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 qual_edge;
  logic                 handshake;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  sync_glitch_filter #(
    .FILTER_LEN  (FILTER_LEN),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_filter (
    .o_clk      (o_clk),
    .rst        (rst),
    .i_signal   (i_signal),
    .o_level    (o_level),
    .o_rise     (o_rise),
    .o_fall     (o_fall),
    .o_rise_nxt (rise_nxt),
    .o_fall_nxt (fall_nxt)
  );

  // Accumulator next-state: read restarts the count, edges increment with saturation.
  always_comb begin
    qual_edge = edge_qualifies(EDGE_MODE, rise_nxt, fall_nxt);
    handshake = (acc_q != '0) && i_evt_ready;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (handshake) begin
      acc_d = qual_edge ? ACC_ONE : '0;
    end else if (qual_edge) begin
      if (acc_q == ACC_MAX) begin
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_q + ACC_ONE;
      end
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge o_clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_evt_count = acc_q;
  assign o_evt_valid = (acc_q != '0);
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_signal_edge_capture.sv
// Directed bench for signal_edge_capture: three instances cover rising-edge
// counting, a 2-bit saturating counter and both-edge counting.
module tb_signal_edge_capture;

  logic o_clk = 1'b0;
  logic rst   = 1'b1;

  // Instance 0: FILTER_LEN=4, CNT_WIDTH=8, rising edges
  logic       s0 = 0, rdy0 = 0, clr0 = 0;
  logic       lvl0, rise0, fall0, vld0, ovf0;
  logic [7:0] cnt0;
  // Instance 1: FILTER_LEN=4, CNT_WIDTH=2, rising edges
  logic       s1 = 0, rdy1 = 0, clr1 = 0;
  logic       lvl1, rise1, fall1, vld1, ovf1;
  logic [1:0] cnt1;
  // Instance 2: FILTER_LEN=4, CNT_WIDTH=8, both edges
  logic       s2 = 0, rdy2 = 0, clr2 = 0;
  logic       lvl2, rise2, fall2, vld2, ovf2;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 o_clk = ~o_clk;

  signal_edge_capture #(.FILTER_LEN(4), .CNT_WIDTH(8), .EDGE_MODE(0), .RESET_LEVEL(1'b0)) dut0 (
    .o_clk(o_clk), .rst(rst), .i_signal(s0), .o_level(lvl0), .o_rise(rise0), .o_fall(fall0),
    .o_evt_valid(vld0), .i_evt_ready(rdy0), .o_evt_count(cnt0), .o_overflow(ovf0), .i_clr_ovf(clr0));

  signal_edge_capture #(.FILTER_LEN(4), .CNT_WIDTH(2), .EDGE_MODE(0), .RESET_LEVEL(1'b0)) dut1 (
    .o_clk(o_clk), .rst(rst), .i_signal(s1), .o_level(lvl1), .o_rise(rise1), .o_fall(fall1),
    .o_evt_valid(vld1), .i_evt_ready(rdy1), .o_evt_count(cnt1), .o_overflow(ovf1), .i_clr_ovf(clr1));

  signal_edge_capture #(.FILTER_LEN(4), .CNT_WIDTH(8), .EDGE_MODE(2), .RESET_LEVEL(1'b0)) dut2 (
    .o_clk(o_clk), .rst(rst), .i_signal(s2), .o_level(lvl2), .o_rise(rise2), .o_fall(fall2),
    .o_evt_valid(vld2), .i_evt_ready(rdy2), .o_evt_count(cnt2), .o_overflow(ovf2), .i_clr_ovf(clr2));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge o_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with the input toggling
    for (int i = 0; i < 3; i++) begin
      s0 = ~s0; s1 = ~s1; s2 = ~s2;
      tick(1);
    end
    s0 = 0; s1 = 0; s2 = 0;
    chk("rst_level", lvl0, 0);
    chk("rst_rise", rise0, 0);
    chk("rst_fall", fall0, 0);
    chk("rst_valid", vld0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ovf", ovf0, 0);

    // Clean rise on instance 0
    rst = 0;
    s0 = 1;
    tick(3);
    chk("rise_e3_level", lvl0, 0);
    chk("rise_e3_count", cnt0, 0);
    tick(1);
    chk("rise_e4_level", lvl0, 1);
    chk("rise_e4_pulse", rise0, 1);
    chk("rise_e4_count", cnt0, 1);
    chk("rise_e4_valid", vld0, 1);
    tick(1);
    chk("rise_e5_pulse", rise0, 0);
    chk("rise_e5_level", lvl0, 1);

    // Fall: pulse only, not counted
    s0 = 0;
    tick(4);
    chk("fall_pulse", fall0, 1);
    chk("fall_no_rise", rise0, 0);
    chk("fall_level", lvl0, 0);
    chk("fall_count", cnt0, 1);
    tick(1);
    chk("fall_pulse_end", fall0, 0);

    // Glitch of 3 samples is rejected
    s0 = 1;
    tick(3);
    chk("glitch_level", lvl0, 0);
    chk("glitch_rise", rise0, 0);
    s0 = 0;
    tick(1);
    chk("glitch_level_after", lvl0, 0);
    chk("glitch_rise_after", rise0, 0);
    chk("glitch_count", cnt0, 1);

    // Exactly 4 samples high gives one rise
    s0 = 1;
    tick(4);
    chk("len4_rise", rise0, 1);
    chk("len4_count", cnt0, 2);
    s0 = 0;
    tick(4);
    chk("len4_fall_level", lvl0, 0);

    // Drain, then accumulate 3 rises with ready low
    rdy0 = 1;
    tick(1);
    rdy0 = 0;
    chk("drain_count", cnt0, 0);
    chk("drain_valid", vld0, 0);
    for (int i = 0; i < 3; i++) begin
      s0 = 1; tick(4);
      s0 = 0; tick(4);
    end
    chk("hs_count3", cnt0, 3);
    rdy0 = 1;
    tick(1);
    rdy0 = 0;
    chk("hs_read_count", cnt0, 0);
    chk("hs_read_valid", vld0, 0);

    // Read coincident with a rise keeps the new edge
    s0 = 1; tick(4);
    chk("hs_pre_count", cnt0, 1);
    s0 = 0; tick(4);
    s0 = 1; tick(3);
    rdy0 = 1;
    tick(1);
    rdy0 = 0;
    chk("hs_coinc_rise", rise0, 1);
    chk("hs_coinc_count", cnt0, 1);
    chk("hs_coinc_valid", vld0, 1);

    // Saturation on the 2-bit instance
    for (int i = 0; i < 3; i++) begin
      s1 = 1; tick(4);
      s1 = 0; tick(4);
    end
    chk("sat_count3", cnt1, 3);
    chk("sat_no_ovf", ovf1, 0);
    for (int i = 0; i < 2; i++) begin
      s1 = 1; tick(4);
      s1 = 0; tick(4);
    end
    chk("sat_count_hold", cnt1, 3);
    chk("sat_ovf", ovf1, 1);
    clr1 = 1;
    tick(1);
    clr1 = 0;
    chk("sat_clr", ovf1, 0);
    s1 = 1; tick(3);
    clr1 = 1;
    tick(1);
    clr1 = 0;
    chk("sat_set_wins_rise", rise1, 1);
    chk("sat_set_wins", ovf1, 1);

    // Both-edge counting
    s2 = 1; tick(4);
    chk("both_rise_count", cnt2, 1);
    s2 = 0; tick(4);
    chk("both_fall_pulse", fall2, 1);
    chk("both_count", cnt2, 2);

    // Reset partway through a filter run
    s2 = 1; tick(2);
    rst = 1;
    tick(1);
    chk("mid_rst_count", cnt2, 0);
    chk("mid_rst_valid", vld2, 0);
    chk("mid_rst_level", lvl2, 0);
    chk("mid_rst_rise", rise2, 0);
    chk("mid_rst_cnt0", cnt0, 0);
    rst = 0;
    tick(3);
    chk("restart_e3_level", lvl2, 0);
    chk("restart_e3_rise", rise2, 0);
    tick(1);
    chk("restart_e4_level", lvl2, 1);
    chk("restart_e4_rise", rise2, 1);
    chk("restart_e4_count", cnt2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
